// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo datapath definitions: default widths, functional-unit
// indices, opcodes and the CDB result record.
package tomasulo_pkg;

  localparam int DATA_W = 16;
  localparam int TAG_W  = 3;
  localparam int REG_AW = 3;
  localparam int NUM_FU = 3;

  localparam int FU_ADD = 0;
  localparam int FU_MUL = 1;
  localparam int FU_MEM = 2;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_LD  = 4'b0010,
    OP_SD  = 4'b0011,
    OP_MUL = 4'b0100
  } opcodeT;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [REG_AW-1:0] dest;
    logic              wen;
    logic [DATA_W-1:0] data;
  } cdbResult;

  // Successor of a round-robin index, wrapping at n.
  function automatic int nextIdx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping modulo N, reported both one-hot and encoded.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grantIdx,
  output logic             anyGrant
);

  logic [IDX_W-1:0] cand;

  // Walk the request vector starting at ptr; the first hit wins and later
  // hits are ignored so at most one grant bit is ever set.
  always_comb begin
    grant    = '0;
    grantIdx = '0;
    anyGrant = 1'b0;
    cand     = '0;
    for (int off = 0; off < N; off++) begin
      cand = IDX_W'((int'(ptr) + off) % N);
      if (!anyGrant && req[cand]) begin
        grant[cand] = 1'b1;
        grantIdx    = cand;
        anyGrant    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one holding slot per functional unit, round-robin
// grant of the single CDB slot, registered broadcast and register-file write.
module cdb_arbiter #(
  parameter int NUM_FU = tomasulo_pkg::NUM_FU,
  parameter int DATA_W = tomasulo_pkg::DATA_W,
  parameter int TAG_W  = tomasulo_pkg::TAG_W,
  parameter int REG_AW = tomasulo_pkg::REG_AW
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_FU-1:0]        fu_valid,
  output logic [NUM_FU-1:0]        fu_ready,
  input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
  input  logic [NUM_FU*REG_AW-1:0] fu_dest,
  input  logic [NUM_FU-1:0]        fu_wen,
  input  logic [NUM_FU*DATA_W-1:0] fu_data,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [DATA_W-1:0]        cdb_data,
  output logic                     rf_we,
  output logic [REG_AW-1:0]        rf_addr,
  output logic [DATA_W-1:0]        rf_data
);

  import tomasulo_pkg::*;

  localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0] held;
  logic [TAG_W-1:0]  slotTag  [NUM_FU];
  logic [REG_AW-1:0] slotDest [NUM_FU];
  logic              slotWen  [NUM_FU];
  logic [DATA_W-1:0] slotData [NUM_FU];

  logic [IDX_W-1:0]  rrPtr;
  logic [IDX_W-1:0]  grantIdx;
  logic [NUM_FU-1:0] grant;
  logic [NUM_FU-1:0] accept;
  logic              anyGrant;

  rr_arbiter #(
    .N     (NUM_FU),
    .IDX_W (IDX_W)
  ) uArb (
    .req      (held),
    .ptr      (rrPtr),
    .grant    (grant),
    .grantIdx (grantIdx),
    .anyGrant (anyGrant)
  );

  // A slot can take a new result when empty or when it is being drained this
  // cycle; this depends on registered state only, never on fu_valid.
  assign fu_ready = ~held | grant;
  assign accept   = fu_valid & fu_ready;
  assign rf_data  = cdb_data;

  // Occupancy: refill wins over drain so a same-edge handoff keeps the slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      held <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (accept[i]) begin
          held[i] <= 1'b1;
        end else if (grant[i]) begin
          held[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (accept[i]) begin
        slotTag[i]  <= fu_tag[i*TAG_W +: TAG_W];
        slotDest[i] <= fu_dest[i*REG_AW +: REG_AW];
        slotWen[i]  <= fu_wen[i];
        slotData[i] <= fu_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Broadcast stage: a granted slot is copied into the output registers and
  // the pointer moves past the winner; idle cycles drop only the strobes.
  always_ff @(posedge clock) begin
    if (reset) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      rf_we     <= 1'b0;
      rf_addr   <= '0;
      rrPtr     <= '0;
    end else if (anyGrant) begin
      cdb_valid <= 1'b1;
      cdb_tag   <= slotTag[grantIdx];
      cdb_data  <= slotData[grantIdx];
      rf_we     <= slotWen[grantIdx];
      rf_addr   <= slotDest[grantIdx];
      rrPtr     <= IDX_W'(nextIdx(int'(grantIdx), NUM_FU));
    end else begin
      cdb_valid <= 1'b0;
      rf_we     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: expected broadcasts (with their cycle)
// are queued as results are offered and checked as the CDB fires.
module tb_cdb_arbiter;

  logic        clock;
  logic        reset;
  logic [2:0]  fuValid;
  logic [2:0]  fuReady;
  logic [8:0]  fuTag;
  logic [8:0]  fuDest;
  logic [2:0]  fuWen;
  logic [47:0] fuData;
  logic        cdbValid;
  logic [2:0]  cdbTag;
  logic [15:0] cdbData;
  logic        rfWe;
  logic [2:0]  rfAddr;
  logic [15:0] rfData;

  typedef struct {
    int tag;
    int dest;
    int wen;
    int data;
    int cyc;
  } expT;

  expT sb[$];
  int  vectors     = 0;
  int  miscompares = 0;
  int  cycle       = 0;
  int  c;

  cdb_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .fu_valid  (fuValid),
    .fu_ready  (fuReady),
    .fu_tag    (fuTag),
    .fu_dest   (fuDest),
    .fu_wen    (fuWen),
    .fu_data   (fuData),
    .cdb_valid (cdbValid),
    .cdb_tag   (cdbTag),
    .cdb_data  (cdbData),
    .rf_we     (rfWe),
    .rf_addr   (rfAddr),
    .rf_data   (rfData)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycle++;

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", name, obs, exp, cycle);
    end
  endtask

  task automatic applyStimulus(input int fu, input int tag, input int dest, input int wen, input int data);
    fuValid[fu]           = 1'b1;
    fuTag[fu*3 +: 3]      = tag[2:0];
    fuDest[fu*3 +: 3]     = dest[2:0];
    fuWen[fu]             = wen[0];
    fuData[fu*16 +: 16]   = data[15:0];
  endtask

  task automatic pushExp(input int tag, input int dest, input int wen, input int data, input int cyc);
    expT e;
    e.tag  = tag;
    e.dest = dest;
    e.wen  = wen;
    e.data = data;
    e.cyc  = cyc;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Scoreboard side: every broadcast must match the oldest outstanding result.
  always @(negedge clock) begin
    expT e;
    if (cdbValid === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpectedBroadcast", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("cdbCycle", cycle, e.cyc);
        checkOutput("cdbTag", cdbTag, e.tag);
        checkOutput("cdbData", cdbData, e.data);
        checkOutput("rfWe", rfWe, e.wen);
        checkOutput("rfData", rfData, e.data);
        if (e.wen != 0) checkOutput("rfAddr", rfAddr, e.dest);
      end
    end
  end

  initial begin
    fuValid = '0; fuTag = '0; fuDest = '0; fuWen = '0; fuData = '0;

    // Reset for two edges with every FU offering junk.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(i, 7, 7, 1, 16'hFFFF);
    tick();
    tick();
    reset = 1'b0;
    fuValid = '0;
    checkOutput("readyAfterReset", fuReady, 3'b111);
    checkOutput("validAfterReset", cdbValid, 1'b0);
    checkOutput("tagAfterReset", cdbTag, 3'd0);
    checkOutput("dataAfterReset", cdbData, 16'h0);
    checkOutput("rfWeAfterReset", rfWe, 1'b0);
    checkOutput("rfAddrAfterReset", rfAddr, 3'd0);
    tick();
    checkOutput("noResetBroadcast", cdbValid, 1'b0);

    // Contention with the pointer at 0: tags 1, 2, 3 in order.
    c = cycle;
    applyStimulus(0, 1, 1, 1, 16'hA001);
    applyStimulus(1, 2, 2, 1, 16'hA002);
    applyStimulus(2, 3, 3, 1, 16'hA003);
    pushExp(1, 1, 1, 16'hA001, c + 2);
    pushExp(2, 2, 1, 16'hA002, c + 3);
    pushExp(3, 3, 1, 16'hA003, c + 4);
    tick();
    checkOutput("contReady0", fuReady, 3'b001);
    fuValid = '0;
    tick();
    checkOutput("contReady1", fuReady, 3'b011);
    tick();
    checkOutput("contReady2", fuReady, 3'b111);
    tick();
    tick();
    checkOutput("contIdle", cdbValid, 1'b0);

    // Single result from FU1.
    c = cycle;
    applyStimulus(1, 5, 3, 1, 16'h1234);
    pushExp(5, 3, 1, 16'h1234, c + 2);
    tick();
    fuValid = '0;
    checkOutput("singleNotYet", cdbValid, 1'b0);
    checkOutput("singleReady", fuReady, 3'b111);
    tick();
    checkOutput("singleValid", cdbValid, 1'b1);
    checkOutput("singleRfWe", rfWe, 1'b1);
    tick();
    checkOutput("singlePulse", cdbValid, 1'b0);
    checkOutput("singleRfWeLow", rfWe, 1'b0);

    // Store result: broadcast without a register write.
    c = cycle;
    applyStimulus(2, 4, 5, 0, 16'h0010);
    pushExp(4, 5, 0, 16'h0010, c + 2);
    tick();
    fuValid = '0;
    tick();
    checkOutput("storeValid", cdbValid, 1'b1);
    checkOutput("storeRfWe", rfWe, 1'b0);
    tick();

    // Fairness: FU0 streams, FU2 offers once and must cut in.
    c = cycle;
    pushExp(1, 4, 1, 16'hB000, c + 2);
    pushExp(6, 6, 1, 16'hC222, c + 3);
    pushExp(1, 4, 1, 16'hB001, c + 4);
    pushExp(1, 4, 1, 16'hB002, c + 5);
    pushExp(1, 4, 1, 16'hB003, c + 6);
    applyStimulus(0, 1, 4, 1, 16'hB000);
    tick();
    checkOutput("fairReady0", fuReady, 3'b111);
    applyStimulus(0, 1, 4, 1, 16'hB001);
    applyStimulus(2, 6, 6, 1, 16'hC222);
    tick();
    checkOutput("fairReady1", fuReady, 3'b110);
    applyStimulus(0, 1, 4, 1, 16'hB002);
    fuValid[2] = 1'b0;
    tick();
    checkOutput("fairReady2", fuReady, 3'b111);
    tick();
    checkOutput("fairReady3", fuReady, 3'b111);
    applyStimulus(0, 1, 4, 1, 16'hB003);
    tick();
    fuValid = '0;
    tick();
    tick();
    checkOutput("fairIdle", cdbValid, 1'b0);

    // Reset while two slots are held; those results must vanish.
    applyStimulus(0, 2, 1, 1, 16'hD000);
    applyStimulus(1, 3, 2, 1, 16'hD001);
    tick();
    fuValid = '0;
    reset = 1'b1;
    applyStimulus(2, 7, 7, 1, 16'hDEAD);
    tick();
    reset = 1'b0;
    fuValid = '0;
    checkOutput("midResetValid", cdbValid, 1'b0);
    checkOutput("midResetReady", fuReady, 3'b111);
    c = cycle;
    applyStimulus(0, 1, 7, 1, 16'hE000);
    applyStimulus(2, 6, 6, 1, 16'hE002);
    pushExp(1, 7, 1, 16'hE000, c + 2);
    pushExp(6, 6, 1, 16'hE002, c + 3);
    tick();
    fuValid = '0;
    tick();
    tick();
    tick();
    checkOutput("postResetIdle", cdbValid, 1'b0);

    // A fresh FU2 result after everything has drained.
    c = cycle;
    applyStimulus(2, 5, 2, 1, 16'hF00D);
    pushExp(5, 2, 1, 16'hF00D, c + 2);
    tick();
    fuValid = '0;

    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    tick();
    checkOutput("scoreboardDrain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
